// File: rtl/sfr_timer_bank.sv
// sfr_timer_bank: bank of 8051-style timer/counters behind a byte-wide SFR port.
// Each channel has TL/TH count bytes, a MODE byte (GATE, C/T, M1, M0) and a
// CTRL byte (TR run, TF overflow flag, IE interrupt enable). Counting is driven
// either by a shared prescaler tick or by falling edges on a synchronised pin.
module sfr_timer_bank #(
  parameter int         CH        = 2,
  parameter int         PRESCALE  = 12,
  parameter logic [7:0] BASE_ADDR = 8'hC0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    addr,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          rd_valid,
  input  logic [CH-1:0] cnt_in,
  input  logic [CH-1:0] gate_in,
  output logic [CH-1:0] tf,
  output logic          irq
);

  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);
  localparam logic [8:0] SPAN      = 9'(4 * CH);

  // Shared prescaler
  logic [7:0] presc_q, presc_d;
  logic       tick;

  // Pin synchronisers and edge detector
  logic [CH-1:0] cnt_s1_q, cnt_s1_d, cnt_s2_q, cnt_s2_d, cnt_prev_q, cnt_prev_d;
  logic [CH-1:0] gate_s1_q, gate_s1_d, gate_s2_q, gate_s2_d;
  logic [CH-1:0] cnt_fall;

  // Read path
  logic [7:0] rdata_q, rdata_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_mux;
  logic [7:0] rd_ch [CH];

  // Address decode
  logic [8:0] off;
  logic       hit;
  logic [1:0] ch_sel;
  logic [1:0] reg_sel;

  logic [CH-1:0] ie_vec;

  assign tick = (presc_q == PRESC_MAX);

  // Offset computed in 9 bits so addresses below the base cannot alias into the bank
  assign off     = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit     = ~off[8] && (off < SPAN);
  assign ch_sel  = off[3:2];
  assign reg_sel = off[1:0];

  // Prescaler wraps at PRESCALE-1; with PRESCALE=1 tick stays high every cycle
  always_comb begin
    presc_d = tick ? 8'd0 : presc_q + 8'd1;
  end

  // Two-flop synchronisers plus one history flop for falling-edge detection
  always_comb begin
    cnt_s1_d   = cnt_in;
    cnt_s2_d   = cnt_s1_q;
    cnt_prev_d = cnt_s2_q;
    gate_s1_d  = gate_in;
    gate_s2_d  = gate_s1_q;
  end

  assign cnt_fall = cnt_prev_q & ~cnt_s2_q;

  // Read data is captured on the strobe and held until the next read
  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < CH; i++) begin
      rd_mux = rd_mux | rd_ch[i];
    end
    rdata_d    = rd_en ? rd_mux : rdata_q;
    rd_valid_d = rd_en;
  end

  // Shared state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      cnt_s1_q   <= '0;
      cnt_s2_q   <= '0;
      cnt_prev_q <= '0;
      gate_s1_q  <= '0;
      gate_s2_q  <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_s1_q   <= cnt_s1_d;
      cnt_s2_q   <= cnt_s2_d;
      cnt_prev_q <= cnt_prev_d;
      gate_s1_q  <= gate_s1_d;
      gate_s2_q  <= gate_s2_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [7:0]  tl_q, tl_d, th_q, th_d;
    logic [3:0]  mode_q, mode_d;
    logic        tr_q, tr_d, tf_q, tf_d, ie_q, ie_d;
    logic        sel, wr_tl, wr_th, wr_mode, wr_ctrl;
    logic        en, inc, ovf;
    logic [7:0]  inc_tl, inc_th;
    logic [12:0] cnt13_nx;
    logic [15:0] cnt16_nx;
    logic [7:0]  rd_val;

    assign sel     = hit && (ch_sel == 2'(gi));
    assign wr_tl   = wr_en && sel && (reg_sel == 2'd0);
    assign wr_th   = wr_en && sel && (reg_sel == 2'd1);
    assign wr_mode = wr_en && sel && (reg_sel == 2'd2);
    assign wr_ctrl = wr_en && sel && (reg_sel == 2'd3);

    // GATE=1 lets the synchronised gate pin qualify the run bit
    assign en  = tr_q & (~mode_q[3] | gate_s2_q[gi]);
    assign inc = en & (mode_q[2] ? cnt_fall[gi] : tick);

    assign cnt13_nx = {th_q, tl_q[4:0]} + 13'd1;
    assign cnt16_nx = {th_q, tl_q} + 16'd1;

    // Candidate count after one increment, by mode; mode 3 leaves everything as is
    always_comb begin
      inc_tl = tl_q;
      inc_th = th_q;
      ovf    = 1'b0;
      case (mode_q[1:0])
        2'd0: begin
          inc_tl = {tl_q[7:5], cnt13_nx[4:0]};
          inc_th = cnt13_nx[12:5];
          ovf    = &{th_q, tl_q[4:0]};
        end
        2'd1: begin
          inc_tl = cnt16_nx[7:0];
          inc_th = cnt16_nx[15:8];
          ovf    = &{th_q, tl_q};
        end
        2'd2: begin
          if (tl_q == 8'hFF) begin
            inc_tl = th_q;
            ovf    = 1'b1;
          end else begin
            inc_tl = tl_q + 8'd1;
          end
        end
        default: begin
          ovf = 1'b0;
        end
      endcase
    end

    // CPU writes to either count byte discard the increment entirely; overflow beats a TF clear
    always_comb begin
      tl_d   = tl_q;
      th_d   = th_q;
      mode_d = mode_q;
      tr_d   = tr_q;
      tf_d   = tf_q;
      ie_d   = ie_q;
      if (wr_tl || wr_th) begin
        if (wr_tl) tl_d = wdata;
        if (wr_th) th_d = wdata;
      end else if (inc) begin
        tl_d = inc_tl;
        th_d = inc_th;
      end
      if (wr_mode) mode_d = wdata[3:0];
      if (wr_ctrl) begin
        tr_d = wdata[0];
        ie_d = wdata[2];
        if (wdata[1]) tf_d = 1'b0;
      end
      if (inc && ovf && !(wr_tl || wr_th)) tf_d = 1'b1;
    end

    // Per-channel register file
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tl_q   <= '0;
        th_q   <= '0;
        mode_q <= '0;
        tr_q   <= 1'b0;
        tf_q   <= 1'b0;
        ie_q   <= 1'b0;
      end else begin
        tl_q   <= tl_d;
        th_q   <= th_d;
        mode_q <= mode_d;
        tr_q   <= tr_d;
        tf_q   <= tf_d;
        ie_q   <= ie_d;
      end
    end

    // Register view for the read mux; unused upper bits read as zero
    always_comb begin
      rd_val = 8'h00;
      case (reg_sel)
        2'd0:    rd_val = tl_q;
        2'd1:    rd_val = th_q;
        2'd2:    rd_val = {4'h0, mode_q};
        default: rd_val = {5'h00, ie_q, tf_q, tr_q};
      endcase
    end

    assign rd_ch[gi]  = sel ? rd_val : 8'h00;
    assign tf[gi]     = tf_q;
    assign ie_vec[gi] = ie_q;
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign irq      = |(tf & ie_vec);

endmodule

// File: tb/tb_sfr_timer_bank.sv
// Bench for sfr_timer_bank: reads push expected bytes into a scoreboard queue,
// a monitor pops and compares whenever rd_valid is seen.
module tb_sfr_timer_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rd_valid;
  logic [1:0] cnt_in = 2'b11;
  logic [1:0] gate_in = 2'b00;
  logic [1:0] tf;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  typedef struct {
    logic [7:0] a;
    logic [7:0] e;
  } exp_t;
  exp_t       sb_q[$];
  logic [7:0] last_rdata = 8'h00;

  sfr_timer_bank #(.CH(2), .PRESCALE(12), .BASE_ADDR(8'hC0)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .cnt_in(cnt_in),
    .gate_in(gate_in), .tf(tf), .irq(irq)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    exp_t t;
    t.a = a; t.e = e;
    sb_q.push_back(t);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_to(input int n);
    int guard = 0;
    if (cyc > n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_to: cycle %0d already past required %0d", cyc, n);
    end
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one line per read transaction that mismatches, plus rdata hold check
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rdata = 8'h00;
      end else if (rd_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: got rd_valid=1 rdata=%02h expected no pending read", rdata);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("rd_%02h", e.a), rdata, e.e);
        end
        last_rdata = rdata;
      end else begin
        chk("rdata_hold", rdata, last_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state
    rd(8'hC0, 8'h00); rd(8'hC1, 8'h00); rd(8'hC2, 8'h00); rd(8'hC3, 8'h00); rd(8'hC7, 8'h00);
    chk("reset_tf", 8'(tf), 8'h00);
    chk("reset_irq", 8'(irq), 8'h00);

    // Mode 1 rollover FFFE -> FFFF -> 0000 with TF
    do_reset();
    wr(8'hC0, 8'hFE); wr(8'hC1, 8'hFF); wr(8'hC2, 8'h01); wr(8'hC3, 8'h01);
    wait_to(11);
    rd(8'hC0, 8'hFE);
    rd(8'hC0, 8'hFF);
    rd(8'hC1, 8'hFF);
    wait_to(23);
    chk("m1_tf_before", 8'(tf), 8'h00);
    rd(8'hC3, 8'h01);
    chk("m1_tf_after", 8'(tf), 8'h01);
    chk("m1_irq_masked", 8'(irq), 8'h00);
    rd(8'hC0, 8'h00);
    rd(8'hC1, 8'h00);
    rd(8'hC3, 8'h03);

    // TL write on the overflow cycle wins and suppresses TF
    do_reset();
    wr(8'hC0, 8'hFF); wr(8'hC1, 8'hFF); wr(8'hC2, 8'h01); wr(8'hC3, 8'h01);
    wait_to(11);
    wr(8'hC0, 8'h55);
    rd(8'hC0, 8'h55);
    rd(8'hC1, 8'hFF);
    rd(8'hC3, 8'h01);
    chk("wrwin_tf", 8'(tf), 8'h00);

    // Mode 2 reload, TF write-0 no effect, overflow beats clear, clear works
    do_reset();
    wr(8'hC0, 8'hFF); wr(8'hC1, 8'hFE); wr(8'hC2, 8'h02); wr(8'hC3, 8'h01);
    wait_to(12);
    rd(8'hC0, 8'hFE);
    rd(8'hC1, 8'hFE);
    wr(8'hC3, 8'h01);
    rd(8'hC3, 8'h03);
    wait_to(35);
    wr(8'hC3, 8'h03);
    chk("ovf_beats_clr", 8'(tf), 8'h01);
    rd(8'hC3, 8'h03);
    wr(8'hC3, 8'h03);
    rd(8'hC3, 8'h01);

    // Ch1 mode 2 counter on cnt_in falling edges, IE set
    do_reset();
    wr(8'hC5, 8'hF0); wr(8'hC4, 8'hFE); wr(8'hC6, 8'h06); wr(8'hC7, 8'h05);
    chk("cnt_irq_before", 8'(irq), 8'h00);
    repeat (3) begin
      cnt_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      cnt_in[1] = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    rd(8'hC4, 8'hF1);
    rd(8'hC5, 8'hF0);
    rd(8'hC7, 8'h07);
    rd(8'hC3, 8'h00);
    chk("cnt_tf", 8'(tf), 8'h02);
    chk("cnt_irq", 8'(irq), 8'h01);

    // Gate: held while gate low, resumes after two-flop sync delay
    do_reset();
    wr(8'hC2, 8'h09); wr(8'hC3, 8'h01);
    wait_to(105);
    rd(8'hC0, 8'h00);
    gate_in[0] = 1'b1;
    wait_to(108);
    rd(8'hC0, 8'h00);
    wait_to(120);
    rd(8'hC0, 8'h01);
    rd(8'hC1, 8'h00);
    gate_in[0] = 1'b0;

    // Unmapped addresses and masked register bits
    do_reset();
    rd(8'hC8, 8'h00);
    rd(8'hBF, 8'h00);
    wr(8'hC8, 8'hAA);
    rd(8'hC8, 8'h00);
    wr(8'hC2, 8'hFF);
    rd(8'hC2, 8'h0F);
    wr(8'hC3, 8'hFF);
    rd(8'hC3, 8'h05);
    chk("unmap_irq", 8'(irq), 8'h00);

    // Mode 0 13-bit rollover on ch0, mode 3 hold on ch1
    do_reset();
    wr(8'hC0, 8'hFF); wr(8'hC1, 8'hFF); wr(8'hC2, 8'h00); wr(8'hC3, 8'h01);
    wr(8'hC4, 8'hFF); wr(8'hC5, 8'hFF); wr(8'hC6, 8'h03); wr(8'hC7, 8'h01);
    wait_to(12);
    rd(8'hC0, 8'hE0);
    rd(8'hC1, 8'h00);
    rd(8'hC3, 8'h03);
    rd(8'hC4, 8'hFF);
    rd(8'hC5, 8'hFF);
    rd(8'hC7, 8'h01);
    chk("m0_m3_tf", 8'(tf), 8'h01);

    // Asynchronous reset mid-count, then counting only after TR rewrite
    do_reset();
    wr(8'hC0, 8'hFF); wr(8'hC1, 8'hFF); wr(8'hC2, 8'h01); wr(8'hC3, 8'h05);
    wait_to(13);
    rd(8'hC3, 8'h07);
    chk("pre_rst_tf", 8'(tf), 8'h01);
    chk("pre_rst_irq", 8'(irq), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tf", 8'(tf), 8'h00);
    chk("async_rst_irq", 8'(irq), 8'h00);
    chk("async_rst_rdata", rdata, 8'h00);
    chk("async_rst_rd_valid", 8'(rd_valid), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(8'hC0, 8'h00);
    rd(8'hC3, 8'h00);
    rd(8'hC2, 8'h00);
    rd(8'hC1, 8'h00);
    wait_to(13);
    rd(8'hC0, 8'h00);
    wr(8'hC3, 8'h01);
    wait_to(24);
    rd(8'hC0, 8'h01);

    repeat (3) @(negedge clk);
    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sfr_timer_bank.md
SFR_TIMER_BANK -- requirements
Module: sfr_timer_bank

Interface
REQ-001 SHALL have parameter CH, default 2, number of timer/counter channels (legal 1..4).
REQ-002 SHALL have parameter PRESCALE, default 12, clk cycles per timer tick (legal 1..255).
REQ-003 SHALL have parameter BASE_ADDR, default 8'hC0, first SFR address of the bank.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port addr  input  8  SFR address.
REQ-007 SHALL have port wr_en  input  1  write strobe, one cycle per write.
REQ-008 SHALL have port rd_en  input  1  read strobe, one cycle per read.
REQ-009 SHALL have port wdata  input  8  write data.
REQ-010 SHALL have port rdata  output  8  registered read data.
REQ-011 SHALL have port rd_valid  output  1  rdata-valid pulse.
REQ-012 SHALL have port cnt_in  input  CH  external count pins, one per channel, asynchronous.
REQ-013 SHALL have port gate_in  input  CH  external gate pins, one per channel, asynchronous.
REQ-014 SHALL have port tf  output  CH  per-channel overflow flags.
REQ-015 SHALL have port irq  output  1  OR over channels of (tf & IE).

Function
REQ-016 SHALL map channel i at BASE_ADDR+4i: +0 TL, +1 TH, +2 MODE (bits[3:0] = GATE, C/T, M1, M0; bits[7:4] read 0), +3 CTRL (bit0 TR run, bit1 TF, bit2 IE; bits[7:3] read 0).
REQ-017 SHALL ignore writes to unmapped addresses and return 8'h00 on reads of them.
REQ-018 SHALL register reads: rd_en at cycle N -> rdata and rd_valid=1 at cycle N+1; rd_valid=0 and rdata holds its last value otherwise.
REQ-019 SHALL treat a write of 1 to CTRL.TF as clear, a write of 0 as no effect; TR and IE are plain read/write bits.
REQ-020 SHALL run a free-running prescaler counting 0..PRESCALE-1, issuing a one-cycle tick when it equals PRESCALE-1; PRESCALE=1 gives a tick every cycle.
REQ-021 SHALL synchronise cnt_in and gate_in through two flops each, and detect cnt_in falling edges on the synchronised signal.
REQ-022 SHALL define channel enable = TR & (~GATE | gate_sync).
REQ-023 SHALL increment an enabled channel once per tick when C/T=0, and once per detected falling edge when C/T=1, independent of tick.
REQ-024 Mode 0 SHALL count 13 bits {TH, TL[4:0]}; TL[7:5] holds; 0x1FFF -> 0 sets TF.
REQ-025 Mode 1 SHALL count 16 bits {TH, TL}; 0xFFFF -> 0 sets TF.
REQ-026 Mode 2 SHALL count TL only; TL=0xFF reloads TL from TH and sets TF; TH is unchanged.
REQ-027 Mode 3 SHALL hold the channel with no increments and no TF set.
REQ-028 SHALL let a CPU write to TL or TH in the same cycle as an increment win; that increment is discarded for both bytes.
REQ-029 SHALL let an overflow set win over a same-cycle TF clear.
REQ-030 SHALL apply MODE and TR changes from the next clock cycle without clearing the count.
REQ-031 SHALL drive tf[i] directly from CTRL.TF of channel i, and irq combinationally from tf and IE.

Reset
REQ-032 On rst_n low, asynchronously clear all TL, TH, MODE, CTRL, the prescaler, the synchroniser/edge flops, rdata and rd_valid; tf=0 and irq=0.
REQ-033 Reset asserted mid-count SHALL abort counting; after release, counting resumes only once TR is rewritten.

Verification
REQ-034 PRESCALE=12, ch0 mode1, TH/TL=FF/FE, TR=1 -> 0xFFFF after 12 cycles, 0x0000 and tf[0]=1 after 24 cycles.
REQ-035 ch1 mode2, TH=0xF0, TL=0xFE, C/T=1, IE=1, 3 falling edges on cnt_in[1] -> TL=0xF1, tf[1]=1, irq=1.
REQ-036 ch0 GATE=1, TR=1, gate_in[0]=0 for 100 cycles -> count unchanged; gate_in=1 -> increments resume after the 2-cycle synchroniser delay.
REQ-037 Write TL=0x55 on the overflow cycle -> TL=0x55 and TF not set; write CTRL=0x02 on an overflow cycle -> TF stays 1.
REQ-038 Read BASE_ADDR+4*CH -> rdata=0x00 with rd_valid the next cycle; read MODE after writing 0xFF -> 0x0F.
REQ-039 Assert rst_n low mid-count in mode 1 -> all registers, tf and irq read 0 immediately, with no clk edge required.
